// File: rtl/pic_cmd_sequencer.sv
// Host-bus interface and command sequencer for the interrupt controller.
// Synchronises the CPU strobes into clk, runs the ICW1..ICW4 initialisation
// sequence, decodes OCW1..OCW3 and drives the IRR/ISR/IMR read-back path.
module pic_cmd_sequencer #(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned SYNC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdn,
    input  logic             wrn,
    input  logic             CSn,
    input  logic             A0,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             dout_en,
    input  logic [N_IRQ-1:0] irr,
    input  logic [N_IRQ-1:0] isr,
    output logic             init_done,
    output logic             icw1_pulse,
    output logic             ltim,
    output logic             sngl,
    output logic             aeoi,
    output logic             sfnm,
    output logic             buf_mode,  // ICW4 BUF bit; 'buf' is a reserved word
    output logic             ms,
    output logic             upm,
    output logic [4:0]       vec_base,
    output logic [7:0]       cas_cfg,
    output logic [N_IRQ-1:0] imr,
    output logic             ocw2_stb,
    output logic [2:0]       ocw2_rsl,
    output logic [2:0]       ocw2_lvl,
    output logic             smm,
    output logic             poll_stb
);

    typedef enum logic [2:0] {StUninit, StIcw2, StIcw3, StIcw4, StReady} state_t;

    state_t          state;
    logic            ic4;
    logic            rd_sel;       // 0 = IRR, 1 = ISR
    logic [SYNC-1:0] rdn_sync;
    logic [SYNC-1:0] wrn_sync;
    logic [SYNC-1:0] csn_sync;
    logic            wrn_prev;
    logic            wr_armed;
    logic            a0_lat;
    logic [7:0]      din_lat;
    logic            rdn_s;
    logic            wrn_s;
    logic            csn_s;
    logic            wr_commit;
    logic            rd_active;
    logic [7:0]      rd_data;

    assign rdn_s     = rdn_sync[SYNC-1];
    assign wrn_s     = wrn_sync[SYNC-1];
    assign csn_s     = csn_sync[SYNC-1];
    assign wr_commit = wrn_s && !wrn_prev && wr_armed;
    // A simultaneous write wins: no bus drive while wrn is low.
    assign rd_active = !csn_s && !rdn_s && wrn_s;

    // Strobe synchronisers, write arming and write-data capture.
    // wrn resets low so a strobe already low at reset release never sees a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdn_sync <= '1;
            csn_sync <= '1;
            wrn_sync <= '0;
            wrn_prev <= 1'b0;
            wr_armed <= 1'b0;
            a0_lat   <= 1'b0;
            din_lat  <= 8'h00;
        end else begin
            rdn_sync <= {rdn_sync[SYNC-2:0], rdn};
            csn_sync <= {csn_sync[SYNC-2:0], CSn};
            wrn_sync <= {wrn_sync[SYNC-2:0], wrn};
            wrn_prev <= wrn_s;
            if (!wrn_s) begin
                // Arm on a fresh falling edge; any CSn-high cycle in the low phase aborts.
                if (wrn_prev) begin
                    wr_armed <= !csn_s;
                end else if (csn_s) begin
                    wr_armed <= 1'b0;
                end
                if (!csn_s) begin
                    a0_lat  <= A0;
                    din_lat <= din;
                end
            end
        end
    end

    // Command decode: initialisation sequence, OCW handling and one-cycle strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StUninit;
            init_done  <= 1'b0;
            icw1_pulse <= 1'b0;
            ltim       <= 1'b0;
            sngl       <= 1'b0;
            ic4        <= 1'b0;
            aeoi       <= 1'b0;
            sfnm       <= 1'b0;
            buf_mode   <= 1'b0;
            ms         <= 1'b0;
            upm        <= 1'b0;
            vec_base   <= 5'd0;
            cas_cfg    <= 8'h00;
            imr        <= '0;
            ocw2_stb   <= 1'b0;
            ocw2_rsl   <= 3'd0;
            ocw2_lvl   <= 3'd0;
            smm        <= 1'b0;
            poll_stb   <= 1'b0;
            rd_sel     <= 1'b0;
        end else begin
            icw1_pulse <= 1'b0;
            ocw2_stb   <= 1'b0;
            poll_stb   <= 1'b0;
            if (wr_commit) begin
                if (!a0_lat && din_lat[4]) begin
                    // ICW1 restarts initialisation from any state.
                    ltim       <= din_lat[3];
                    sngl       <= din_lat[1];
                    ic4        <= din_lat[0];
                    imr        <= '0;
                    smm        <= 1'b0;
                    aeoi       <= 1'b0;
                    sfnm       <= 1'b0;
                    buf_mode   <= 1'b0;
                    ms         <= 1'b0;
                    upm        <= 1'b0;
                    cas_cfg    <= 8'h00;
                    rd_sel     <= 1'b0;
                    icw1_pulse <= 1'b1;
                    init_done  <= 1'b0;
                    state      <= StIcw2;
                end else if (a0_lat) begin
                    case (state)
                        StIcw2: begin
                            vec_base <= din_lat[7:3];
                            if (!sngl) begin
                                state <= StIcw3;
                            end else if (ic4) begin
                                state <= StIcw4;
                            end else begin
                                state     <= StReady;
                                init_done <= 1'b1;
                            end
                        end
                        StIcw3: begin
                            cas_cfg <= din_lat;
                            if (ic4) begin
                                state <= StIcw4;
                            end else begin
                                state     <= StReady;
                                init_done <= 1'b1;
                            end
                        end
                        StIcw4: begin
                            upm       <= din_lat[0];
                            aeoi      <= din_lat[1];
                            ms        <= din_lat[2];
                            buf_mode  <= din_lat[3];
                            sfnm      <= din_lat[4];
                            state     <= StReady;
                            init_done <= 1'b1;
                        end
                        StReady: imr <= din_lat[N_IRQ-1:0];
                        default: ;
                    endcase
                end else if (state == StReady) begin
                    if (din_lat[4:3] == 2'b00) begin
                        ocw2_rsl <= din_lat[7:5];
                        ocw2_lvl <= din_lat[2:0];
                        ocw2_stb <= 1'b1;
                    end else begin
                        // A0=0 with d[4]=0 leaves d[4:3]=01 here: OCW3.
                        if (din_lat[6:5] == 2'b11) begin
                            smm <= 1'b1;
                        end else if (din_lat[6:5] == 2'b10) begin
                            smm <= 1'b0;
                        end
                        if (din_lat[1]) begin
                            rd_sel <= din_lat[0];
                        end
                        if (din_lat[2]) begin
                            poll_stb <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Read-back mux; unused upper bits read as zero, nothing is visible before init starts.
    always_comb begin
        rd_data = 8'h00;
        if (state != StUninit) begin
            if (A0) begin
                rd_data[N_IRQ-1:0] = imr;
            end else if (rd_sel) begin
                rd_data[N_IRQ-1:0] = isr;
            end else begin
                rd_data[N_IRQ-1:0] = irr;
            end
        end
    end

    // Registered bus drive; dout follows irr/isr live while the read is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= 8'h00;
            dout_en <= 1'b0;
        end else begin
            dout_en <= rd_active;
            dout    <= rd_active ? rd_data : 8'h00;
        end
    end

endmodule
